// File: rtl/pc_write_ctrl_pkg.sv
// Shared definitions for the PC write controller: FSM encoding, default
// vectors, the sequential PC increment and the load-use hazard test.
package pc_write_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0180;
    localparam logic [31:0] PC_INC           = 32'd4;

    // A load in ID/EX whose destination feeds the instruction in IF/ID.
    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       memread,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pc_stall_counter.sv
// Loadable down-counter that times the mult/div stall. It holds at zero
// rather than wrapping, and a load takes precedence over a decrement.
module pc_stall_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load, decrement toward zero, or hold.
    always_comb begin
        // NOTE: assigning the default first means every path writes cnt_d,
        // so no latch is inferred for the hold case.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignment keeps every flop sampling the
        // pre-edge values, whatever order the simulator runs the blocks in.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pc_write_ctrl.sv
// Producer side of the PC register: picks nextPC and the PC / IF-ID write
// enables each cycle, arbitrating exception, branch, jump, load-use and
// mult/div stalls, and raises the pipeline flush strobes.
module pc_write_ctrl
    import pc_write_ctrl_pkg::*;
#(
    parameter int          MD_LATENCY   = 32,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        md_start,
    output logic [31:0] nextPC,
    output logic        pc_enable,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_busy
);

    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    state_e      state_q,  state_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_t_q, pend_t_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    logic [31:0] pc_plus4;
    logic        hazard;

    assign pc_plus4 = PC + PC_INC;
    assign hazard   = load_use_hazard(id_ex_memread, id_ex_rt, if_id_rs, if_id_rt);

    pc_stall_counter #(
        .WIDTH (CNT_W)
    ) u_stall_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, pending-redirect capture and the output mux.
    always_comb begin
        state_d      = state_q;
        pend_v_d     = pend_v_q;
        pend_t_d     = pend_t_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        nextPC       = pc_plus4;
        pc_enable    = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        md_busy      = 1'b0;

        if (rst) begin
            // Registers are cleared asynchronously; only the outputs need forcing.
            nextPC = RESET_VECTOR;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (exception) begin
                        nextPC      = EXC_VECTOR;
                        pc_enable   = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (md_start) begin
                        // The start cycle is the first of MD_LATENCY hold cycles.
                        state_d      = MD_BUSY;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(MD_LATENCY - 1);
                        if (branch_taken) begin
                            pend_v_d = 1'b1;
                            pend_t_d = branch_target;
                        end else if (jump) begin
                            pend_v_d = 1'b1;
                            pend_t_d = jump_target;
                        end
                    end else if (branch_taken) begin
                        nextPC      = branch_target;
                        pc_enable   = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (jump) begin
                        nextPC      = jump_target;
                        pc_enable   = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (hazard) begin
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_enable   = 1'b1;
                        if_id_write = 1'b1;
                    end
                end

                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (exception) begin
                        state_d      = RUN;
                        pend_v_d     = 1'b0;
                        cnt_load     = 1'b1;
                        cnt_load_val = '0;
                        nextPC       = EXC_VECTOR;
                        pc_enable    = 1'b1;
                        if_id_write  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end else begin
                        // First redirect seen during the stall is kept; branch beats jump.
                        if (!pend_v_q && (branch_taken || jump)) begin
                            pend_v_d = 1'b1;
                            pend_t_d = branch_taken ? branch_target : jump_target;
                        end
                        if (!cnt_zero) begin
                            cnt_dec = 1'b1;
                        end else begin
                            // A redirect arriving on the release cycle itself is
                            // used straight away instead of being dropped.
                            state_d     = RUN;
                            pc_enable   = 1'b1;
                            if_id_write = 1'b1;
                            if (pend_v_d) begin
                                nextPC      = pend_t_d;
                                if_id_flush = 1'b1;
                                id_ex_flush = 1'b1;
                            end
                            pend_v_d = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // FSM state and pending-redirect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pend_v_q <= 1'b0;
            pend_t_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_v_q <= pend_v_d;
            pend_t_q <= pend_t_d;
        end
    end

endmodule
